// File: rtl/ibex_pkg.sv
// Shared Ibex types: multi-bit boolean encoding for hardened status signals
// and the state encoding of the core clock sleep sequencer.
package ibex_pkg;

  typedef logic [3:0] ibex_mubi_t;

  localparam ibex_mubi_t IbexMuBiOn  = 4'b0101;
  localparam ibex_mubi_t IbexMuBiOff = 4'b1010;

  // SleepRun and SleepSleep are two bit flips apart, so a single upset from
  // RUN lands in a clock-on state rather than gating the core.
  typedef enum logic [1:0] {
    SleepRun      = 2'b01,
    SleepIdleWait = 2'b11,
    SleepSleep    = 2'b10,
    SleepWake     = 2'b00
  } sleep_state_e;

endpackage

// File: rtl/ibex_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ibex_sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ibex_sleep_ctrl.sv
// Sleep/wake sequencer for the core clock gate: idle hysteresis before gating,
// a forced-on hold-off after waking, a sleep-cycle statistic and a busy alert.
module ibex_sleep_ctrl
  import ibex_pkg::*;
#(
  parameter bit          SecureIbex = 1'b0,
  parameter int unsigned IdleHyst   = 4,
  parameter int unsigned WakeHold   = 2,
  parameter int unsigned CntWidth   = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [3:0]          core_busy_i,
  input  logic                debug_req_i,
  input  logic                irq_pending_i,
  input  logic                irq_nm_i,
  input  logic                cnt_clr_i,
  output logic                clock_en_o,
  output logic                core_sleep_o,
  output logic                wake_o,
  output logic [CntWidth-1:0] sleep_cycles_o,
  output logic                alert_o
);

  localparam int unsigned TmrMax = (IdleHyst > WakeHold) ? IdleHyst : WakeHold;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0] IdleLoad = TmrW'((IdleHyst > 0) ? IdleHyst - 1 : 0);
  localparam logic [TmrW-1:0] HoldLoad = TmrW'((WakeHold > 0) ? WakeHold - 1 : 0);

  sleep_state_e    state_q;
  ibex_mubi_t      busy_q;
  logic [TmrW-1:0] tmr_q;
  logic            wake_q;
  logic            alert_q;

  logic wake_any, illegal, busy, idle;

  assign wake_any = debug_req_i | irq_pending_i | irq_nm_i;
  assign illegal  = (busy_q != IbexMuBiOn) && (busy_q != IbexMuBiOff);
  // Hardened mode treats anything but a clean Off as busy so faults keep the clock on.
  assign busy     = SecureIbex ? (busy_q != IbexMuBiOff) : busy_q[0];
  assign idle     = ~busy & ~wake_any;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SleepRun;
      busy_q  <= IbexMuBiOff;
      tmr_q   <= '0;
      wake_q  <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      busy_q <= core_busy_i;
      wake_q <= 1'b0;
      if (SecureIbex && illegal) begin
        alert_q <= 1'b1;
      end
      case (state_q)
        SleepRun: begin
          if (idle) begin
            if (IdleHyst > 0) begin
              state_q <= SleepIdleWait;
              tmr_q   <= IdleLoad;
            end else begin
              state_q <= SleepSleep;
            end
          end
        end
        SleepIdleWait: begin
          if (!idle) begin
            state_q <= SleepRun;
          end else if (tmr_q == '0) begin
            state_q <= SleepSleep;
          end else begin
            tmr_q <= tmr_q - TmrW'(1);
          end
        end
        SleepSleep: begin
          if (wake_any) begin
            if (WakeHold > 0) begin
              state_q <= SleepWake;
              tmr_q   <= HoldLoad;
            end else begin
              state_q <= SleepRun;
              wake_q  <= 1'b1;
            end
          end
        end
        SleepWake: begin
          if (tmr_q == '0) begin
            state_q <= SleepRun;
            wake_q  <= 1'b1;
          end else begin
            tmr_q <= tmr_q - TmrW'(1);
          end
        end
        default: state_q <= SleepRun;
      endcase
    end
  end

  // Wake inputs bypass the state register so the first core edge is not delayed.
  assign clock_en_o   = (state_q != SleepSleep) | wake_any;
  assign core_sleep_o = ~clock_en_o;
  assign wake_o       = wake_q;
  assign alert_o      = alert_q;

  ibex_sat_counter #(
    .Width(CntWidth)
  ) u_sleep_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr_i),
    .inc_i  (state_q == SleepSleep),
    .cnt_o  (sleep_cycles_o)
  );

endmodule
